// File: rtl/spi_shift_xfer_if.sv
// Transfer-side signal bundle of the SPI shift engine: word/length request,
// status back to the sequencer, and the three SPI pins.
interface spi_shift_xfer_if #(
  parameter int MaxBits     = 8,
  parameter int MaxBitsLog2 = 4
);
  logic                   mosi;
  logic                   miso;
  logic                   cs_n;
  logic [MaxBits-1:0]     tx_data;
  logic [MaxBitsLog2-1:0] bit_count;
  logic                   keep_cs;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [MaxBits-1:0]     rx_data;

  // Engine side
  modport slave (
    input  miso, tx_data, bit_count, keep_cs, start,
    output mosi, cs_n, busy, done, rx_data
  );

  // Sequencer / SPI-device side
  modport master (
    output miso, tx_data, bit_count, keep_cs, start,
    input  mosi, cs_n, busy, done, rx_data
  );
endinterface

// File: rtl/spi_shift_xfer.sv
// Full-duplex SPI shift engine clocked by the bit clock: variable length
// transfers, selectable bit order, chip-select hold and gapless chaining.
module spi_shift_xfer #(
  parameter int   MaxBits       = 8,
  parameter int   MaxBitsLog2   = 4,
  parameter logic MosiIdleState = 1'b1,
  parameter bit   LsbFirst      = 1'b0
) (
  input logic             sclk,
  input logic             reset,
  spi_shift_xfer_if.slave bus
);

  typedef logic [MaxBitsLog2-1:0] cnt_t;
  typedef logic [MaxBits-1:0]     word_t;

  localparam cnt_t MaxN    = cnt_t'(MaxBits);
  localparam cnt_t MaxLast = cnt_t'(MaxBits - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  state_e state_q;
  word_t  tx_sh_q;
  word_t  rx_sh_q;
  word_t  rx_data_q;
  cnt_t   cnt_q;
  cnt_t   last_q;
  logic   done_q;
  logic   cs_n_q;

  cnt_t  len_n;
  logic  final_edge;
  logic  accept;
  word_t tx_load;
  word_t tx_shifted;
  word_t rx_shifted;
  word_t rx_word;
  logic  out_bit;

  // Zero and oversize lengths both mean a full-width word.
  always_comb begin
    len_n = bus.bit_count;
    if (bus.bit_count == '0 || bus.bit_count > MaxN) begin
      len_n = MaxN;
    end
  end

  assign final_edge = (state_q == ST_SHIFT) && (cnt_q == last_q);
  assign accept     = bus.start && ((state_q == ST_IDLE) || final_edge);

  generate
    if (LsbFirst) begin : g_lsb
      assign tx_load    = bus.tx_data;
      assign tx_shifted = tx_sh_q >> 1;
      assign out_bit    = tx_sh_q[0];
      // Bits enter at the top; a short word ends up MaxBits-N places too high.
      assign rx_shifted = {bus.miso, rx_sh_q[MaxBits-1:1]};
      assign rx_word    = rx_shifted >> (MaxLast - last_q);
    end else begin : g_msb
      // Left-align the active N bits so tx_data[N-1] sits at the output.
      assign tx_load    = bus.tx_data << (MaxN - len_n);
      assign tx_shifted = tx_sh_q << 1;
      assign out_bit    = tx_sh_q[MaxBits-1];
      assign rx_shifted = {rx_sh_q[MaxBits-2:0], bus.miso};
      assign rx_word    = rx_shifted;
    end
  endgenerate

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      done_q <= final_edge;
      if (final_edge) begin
        rx_data_q <= rx_word;
      end

      if (accept) begin
        state_q <= ST_SHIFT;
        tx_sh_q <= tx_load;
        rx_sh_q <= '0;
        cnt_q   <= '0;
        last_q  <= len_n - cnt_t'(1);
        cs_n_q  <= 1'b0;
      end else if (final_edge) begin
        // keep_cs leaves the device selected for a follow-on transfer.
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        cs_n_q  <= ~bus.keep_cs;
      end else if (state_q == ST_SHIFT) begin
        tx_sh_q <= tx_shifted;
        rx_sh_q <= rx_shifted;
        cnt_q   <= cnt_q + cnt_t'(1);
      end
    end
  end

  assign bus.mosi    = (state_q == ST_SHIFT) ? out_bit : MosiIdleState;
  assign bus.busy    = (state_q == ST_SHIFT);
  assign bus.done    = done_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: doc/spi_shift_xfer.md
Name: spi_shift_xfer

Overview:
- Parametrised full-duplex SPI shift engine, successor to the fixed 8-bit transmit-only shifter.
- Adds a per-transaction bit count (1..MaxBits), a MISO receive path, a selectable bit order and a chip-select output.
- Allows gapless back-to-back transfers with chip-select held across them.
- Clocked directly by the SPI bit clock; sits between the frame/command sequencer and the display/flash SPI pins.

Parameters:
MaxBits, 8, maximum bits per transfer; also width of tx_data/rx_data
MaxBitsLog2, 4, width of bit_count and internal counter; must satisfy 2^MaxBitsLog2 > MaxBits
MosiIdleState, 1'b1, mosi level whenever no bit is being driven
LsbFirst, 0, 0 = MSB of the active word first, 1 = bit 0 first

Ports:
sclk  input  1  bit clock; all state on posedge. Single clock domain.
reset  input  1  asynchronous, active-high reset
mosi  output  1  serial data out
miso  input  1  serial data in, sampled on posedge sclk
cs_n  output  1  chip select, active low
tx_data  input  MaxBits  word to send, right-justified; sampled at accept
bit_count  input  MaxBitsLog2  transfer length N; sampled at accept
keep_cs  input  1  sampled at final-bit edge; 1 = hold cs_n low after the transfer
start  input  1  transfer request
busy  output  1  transfer in progress
done  output  1  one-cycle pulse: transfer complete
rx_data  output  MaxBits  received word, right-justified, upper bits zero

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer): busy=0, done=0, cs_n=1, mosi=MosiIdleState, rx_data=0, counter=0. Any partial transfer is discarded; no done pulse.
- Length: N = bit_count, sampled at accept.
  - bit_count=0 gives N=MaxBits.
  - bit_count>MaxBits is clamped to MaxBits.
- Accept edge: posedge with start=1 and busy=0, or the final-bit edge (below) with start=1. Actions:
  - Latch tx_data into the shift buffer, aligned so the first bit is at the output position.
  - Latch N; counter=0; clear the rx shift register.
  - busy=1, cs_n=0.
- Bit cycles: cycles 1..N after accept.
  - mosi = current output bit of the shift buffer. MSB-first sends tx_data[N-1] first; LSB-first sends tx_data[0] first.
  - At each posedge while busy: shift the buffer, sample miso into the rx shift register, increment the counter.
- Final-bit edge: posedge with busy=1 and counter==N-1.
  - done=1 for exactly one cycle.
  - rx_data loads the assembled word. MSB-first: first received bit at rx_data[N-1]. LSB-first: first received bit at rx_data[0].
  - If start=1: new transfer accepted on this same edge. busy stays 1, cs_n stays 0, zero-gap mosi stream, done still pulses.
  - Else: busy=0. cs_n=1 unless keep_cs=1, in which case cs_n stays 0 until the next transfer completes without keep_cs, or reset.
- Idle (busy=0): mosi=MosiIdleState. start has no effect except at accept.
- start while busy and not at the final-bit edge: ignored; tx_data/bit_count changes have no effect.
- rx_data holds its value until the next final-bit edge or reset.
- Latency: start at edge k gives the first bit valid after k and done high after edge k+N. Throughput is one bit per sclk with no inter-word gap when chained.
- N=1: accept and final-bit edges are one cycle apart; busy high for exactly one cycle.
- Counter never exceeds MaxBits-1; no wrap-around.

Test Plan:
- MaxBits=8, LsbFirst=0: start with tx_data=0xA5, bit_count=8, miso driving 0x3C MSB-first -> mosi sequence 1,0,1,0,0,1,0,1; busy high 8 cycles; cs_n low 8 cycles; done pulse once; rx_data=0x3C; mosi returns to 1.
- bit_count=5, tx_data=0x13, miso all ones -> 5 bits 1,0,0,1,1; rx_data=0x1F; busy high 5 cycles.
- Back-to-back: 0xF0 then 0x0F, start held on the final-bit edge -> 16 contiguous bits; busy and cs_n never deassert; two done pulses 8 cycles apart.
- keep_cs=1 on the first transfer, second transfer started 3 idle cycles later -> cs_n stays low across the gap; mosi idle=1 during the gap.
- LsbFirst=1, tx_data=0x01, bit_count=0 -> treated as 8 bits; mosi 1,0,0,0,0,0,0,0; first miso bit appears at rx_data[0].
- reset asserted after the 3rd bit -> busy=0, cs_n=1, mosi=1 immediately; no done pulse. Start pulsed mid-transfer without reset -> ignored; original word completes unchanged.
